risc_ctrl_seq: RTL and testbench
================================

RISC_CTRL_SEQ -- requirements
Module: risc_ctrl_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port instruction, input, 8: memory word; [7:4] opcode, [3:2] src reg, [1:0] dest reg.
REQ-005 SHALL have port zero, input, 1: zero flag from the ALU, registered downstream in Reg_Z.
REQ-006 SHALL have port load_r, output, 4: one-hot load enable for R0..R3.
REQ-007 SHALL have ports load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write, each output, 1: datapath strobes.
REQ-008 SHALL have port sel_bus_1, output, 3: Bus_1 source, 0-3 = R0-R3, 4 = PC.
REQ-009 SHALL have port sel_bus_2, output, 2: Bus_2 source, 0 = ALU, 1 = Bus_1, 2 = memory.
REQ-010 SHALL have port halted, output, 1: high while in S_HALT.
REQ-011 SHALL have port instr_cnt, output, CNT_W: count of instructions retired.

Function
REQ-012 SHALL use the opcodes NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8 and HALT=15; opcodes 9-14 are illegal.
REQ-013 SHALL use the states S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2 and S_HALT.
REQ-014 SHALL decode the outputs combinationally from the current state and instruction only (Moore plus IR); all strobes are 0 unless this spec asserts them.
REQ-015 SHALL move from S_IDLE to S_FET1 on the first clock edge after reset is released.
REQ-016 SHALL in S_FET1 set sel_bus_1=4, sel_bus_2=1 and load_add_r=1, then go to S_FET2.
REQ-017 SHALL in S_FET2 set sel_bus_2=2, load_ir=1 and inc_pc=1, then go to S_DEC.
REQ-018 SHALL in S_DEC for NOP retire and go to S_FET1.
REQ-019 SHALL in S_DEC for ADD/SUB/AND set sel_bus_1=src, sel_bus_2=1 and load_reg_y=1, then go to S_EX1.
REQ-020 SHALL in S_DEC for NOT set sel_bus_1=src, sel_bus_2=0, load_r[dest]=1 and load_reg_z=1, retire, and go to S_FET1.
REQ-021 SHALL in S_DEC for RD/WR/BR/BRZ set sel_bus_1=4, sel_bus_2=1 and load_add_r=1, then go to S_RD1, S_WR1 or S_BR1 respectively.
REQ-022 SHALL in S_DEC for HALT or an illegal opcode go to S_HALT.
REQ-023 SHALL in S_EX1 set sel_bus_1=dest, sel_bus_2=0, load_r[dest]=1 and load_reg_z=1, retire, and go to S_FET1; the ALU is then operating on Reg_Y=src and Bus_1=dest.
REQ-024 SHALL in S_RD1 and S_WR1 set sel_bus_2=2, load_add_r=1 and inc_pc=1, then go to S_RD2 or S_WR2.
REQ-025 SHALL in S_RD2 set sel_bus_2=2 and load_r[dest]=1, then retire.
REQ-026 SHALL in S_WR2 set sel_bus_1=src and write=1, then retire.
REQ-027 SHALL in S_BR1 set sel_bus_2=2 and load_add_r=1, then go to S_BR2.
REQ-028 SHALL in S_BR2 set sel_bus_2=2 and load_pc=1, then retire.
REQ-029 SHALL keep S_HALT absorbing with all strobes 0 and halted=1; only reset exits it.
REQ-030 SHALL increment instr_cnt by 1 on each retire and wrap from all-ones to 0; HALT and illegal opcodes do not retire.

Reset
REQ-031 SHALL while rst=0 force state S_IDLE and instr_cnt=0, with all strobes, selects and halted at 0, independent of clk.
REQ-032 SHALL when reset is asserted mid-instruction abandon that instruction immediately; the counter does not count it.

Configuration
REQ-033 SHALL with macro RISC_CTRL_BRZ_EN defined go from S_DEC on BRZ to S_BR1 when zero=1, and otherwise assert inc_pc=1, retire and go to S_FET1.
REQ-034 SHALL without RISC_CTRL_BRZ_EN treat opcode 8 as illegal and go to S_HALT.

Structure
REQ-035 SHALL place the opcode constants, the state enum and the select encodings in the package risc_ctrl_pkg.
REQ-036 SHALL place the retire counter in the sub-module risc_ctrl_cnt, which takes clk, rst and an inc strobe.

Verification
REQ-037 SHALL check reset release followed by a NOP -> the states run IDLE, FET1, FET2, DEC, FET1 and instr_cnt=1.
REQ-038 SHALL check ADD with src=R1 and dest=R2 (0x16) -> S_DEC gives load_reg_y=1 and sel_bus_1=1; S_EX1 gives load_r=4'b0100 and load_reg_z=1.
REQ-039 SHALL check BRZ 0x80 with the macro defined -> zero=1 leads to load_pc in S_BR2; zero=0 leads to inc_pc in S_DEC and then S_FET1.
REQ-040 SHALL check illegal opcode 0x90 -> S_HALT, halted=1, all strobes 0 and instr_cnt unchanged.
REQ-041 SHALL check rst pulled low during S_WR1 -> write is never asserted and the next cycle after release is S_IDLE.
REQ-042 SHALL check CNT_W=4 after 16 retires -> instr_cnt=0.

Source files
------------

// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg: opcodes, sequencer states and bus select encodings for risc_ctrl_seq
package risc_ctrl_pkg;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_RD   = 4'd5;
  localparam logic [3:0] OP_WR   = 4'd6;
  localparam logic [3:0] OP_BR   = 4'd7;
  localparam logic [3:0] OP_BRZ  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;
  typedef enum logic [3:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2,
    S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
  } state_t;
  localparam logic [2:0] B1_PC   = 3'd4;
  localparam logic [1:0] B2_ALU  = 2'd0;
  localparam logic [1:0] B2_BUS1 = 2'd1;
  localparam logic [1:0] B2_MEM  = 2'd2;
endpackage

// File: rtl/risc_ctrl_cnt.sv
// risc_ctrl_cnt: wrapping retired-instruction counter
// Ports: clk, rst (async active-low), inc (count strobe), cnt (W-bit count)
module risc_ctrl_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/risc_ctrl_seq.sv
// risc_ctrl_seq: control sequencer for a simple 8-bit RISC datapath
// Ports: clk, rst (async active-low), instruction ([7:4] op, [3:2] src, [1:0] dest), zero;
//        datapath strobes load_r/load_pc/inc_pc/load_ir/load_add_r/load_reg_y/load_reg_z/write,
//        bus selects sel_bus_1/sel_bus_2, halted, instr_cnt (retired count).
// Macro RISC_CTRL_BRZ_EN enables BRZ; otherwise opcode 8 halts as illegal.
module risc_ctrl_seq
  import risc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       instruction,
  input  logic             zero,
  output logic [3:0]       load_r,
  output logic             load_pc,
  output logic             inc_pc,
  output logic             load_ir,
  output logic             load_add_r,
  output logic             load_reg_y,
  output logic             load_reg_z,
  output logic             write,
  output logic [2:0]       sel_bus_1,
  output logic [1:0]       sel_bus_2,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);
  state_t state, nxt;
  logic retire;
  logic [3:0] op;
  logic [1:0] src, dest;
  assign op = instruction[7:4];
  assign src = instruction[3:2];
  assign dest = instruction[1:0];
`ifndef RISC_CTRL_BRZ_EN
  logic unused_zero;
  assign unused_zero = zero;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    retire = 1'b0;
    load_r = 4'b0;
    load_pc = 1'b0;
    inc_pc = 1'b0;
    load_ir = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write = 1'b0;
    sel_bus_1 = 3'd0;
    sel_bus_2 = 2'd0;
    halted = 1'b0;
    case (state)
      S_IDLE: nxt = S_FET1;
      S_FET1: begin
        sel_bus_1 = B1_PC;
        sel_bus_2 = B2_BUS1;
        load_add_r = 1'b1;
        nxt = S_FET2;
      end
      S_FET2: begin
        sel_bus_2 = B2_MEM;
        load_ir = 1'b1;
        inc_pc = 1'b1;
        nxt = S_DEC;
      end
      S_DEC:
        case (op)
          OP_NOP: begin
            retire = 1'b1;
            nxt = S_FET1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel_bus_1 = {1'b0, src};
            sel_bus_2 = B2_BUS1;
            load_reg_y = 1'b1;
            nxt = S_EX1;
          end
          OP_NOT: begin
            sel_bus_1 = {1'b0, src};
            sel_bus_2 = B2_ALU;
            load_r = 4'b1 << dest;
            load_reg_z = 1'b1;
            retire = 1'b1;
            nxt = S_FET1;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel_bus_1 = B1_PC;
            sel_bus_2 = B2_BUS1;
            load_add_r = 1'b1;
            nxt = op == OP_RD ? S_RD1 : op == OP_WR ? S_WR1 : S_BR1;
          end
`ifdef RISC_CTRL_BRZ_EN
          // Not-taken BRZ skips the target word in memory by bumping PC here.
          OP_BRZ: begin
            sel_bus_1 = zero ? B1_PC : 3'd0;
            sel_bus_2 = zero ? B2_BUS1 : 2'd0;
            load_add_r = zero;
            inc_pc = !zero;
            retire = !zero;
            nxt = zero ? S_BR1 : S_FET1;
          end
`endif
          default: nxt = S_HALT;
        endcase
      // ALU sees Reg_Y (src) and Bus_1 (dest); result lands back in dest.
      S_EX1: begin
        sel_bus_1 = {1'b0, dest};
        sel_bus_2 = B2_ALU;
        load_r = 4'b1 << dest;
        load_reg_z = 1'b1;
        retire = 1'b1;
        nxt = S_FET1;
      end
      S_RD1, S_WR1: begin
        sel_bus_2 = B2_MEM;
        load_add_r = 1'b1;
        inc_pc = 1'b1;
        nxt = state == S_RD1 ? S_RD2 : S_WR2;
      end
      S_RD2: begin
        sel_bus_2 = B2_MEM;
        load_r = 4'b1 << dest;
        retire = 1'b1;
        nxt = S_FET1;
      end
      S_WR2: begin
        sel_bus_1 = {1'b0, src};
        write = 1'b1;
        retire = 1'b1;
        nxt = S_FET1;
      end
      S_BR1: begin
        sel_bus_2 = B2_MEM;
        load_add_r = 1'b1;
        nxt = S_BR2;
      end
      S_BR2: begin
        sel_bus_2 = B2_MEM;
        load_pc = 1'b1;
        retire = 1'b1;
        nxt = S_FET1;
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_IDLE;
    endcase
  end
  risc_ctrl_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(retire),
    .cnt(instr_cnt)
  );
endmodule

// File: tb/tb_risc_ctrl_seq.sv
// tb_risc_ctrl_seq: directed self-checking bench for risc_ctrl_seq
module tb_risc_ctrl_seq;
  logic clk = 1'b0;
  logic rst, zero, rst2;
  logic [7:0] instruction, ins2;
  logic [3:0] load_r, b_load_r;
  logic load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write, halted;
  logic b_load_pc, b_inc_pc, b_load_ir, b_load_add_r, b_load_reg_y, b_load_reg_z, b_write, b_halted;
  logic [2:0] sel_bus_1, b_sel_bus_1;
  logic [1:0] sel_bus_2, b_sel_bus_2;
  logic [15:0] instr_cnt;
  logic [3:0] cnt2;
  logic [16:0] outs;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  risc_ctrl_seq dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .load_r(load_r), .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir),
    .load_add_r(load_add_r), .load_reg_y(load_reg_y), .load_reg_z(load_reg_z),
    .write(write), .sel_bus_1(sel_bus_1), .sel_bus_2(sel_bus_2),
    .halted(halted), .instr_cnt(instr_cnt)
  );
  risc_ctrl_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst2), .instruction(ins2), .zero(1'b0),
    .load_r(b_load_r), .load_pc(b_load_pc), .inc_pc(b_inc_pc), .load_ir(b_load_ir),
    .load_add_r(b_load_add_r), .load_reg_y(b_load_reg_y), .load_reg_z(b_load_reg_z),
    .write(b_write), .sel_bus_1(b_sel_bus_1), .sel_bus_2(b_sel_bus_2),
    .halted(b_halted), .instr_cnt(cnt2)
  );
  assign outs = {load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z,
                 write, sel_bus_1, sel_bus_2, halted};
  function automatic logic [16:0] v(logic [3:0] lr, logic pc, logic inc, logic ir, logic ar,
                                    logic y, logic z, logic w, logic [2:0] s1, logic [1:0] s2,
                                    logic h);
    return {lr, pc, inc, ir, ar, y, z, w, s1, s2, h};
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [16:0] F1, F2, M1, HLT;
  initial begin
    F1 = v(4'b0, 0, 0, 0, 1, 0, 0, 0, 3'd4, 2'd1, 0);
    F2 = v(4'b0, 0, 1, 1, 0, 0, 0, 0, 3'd0, 2'd2, 0);
    M1 = v(4'b0, 0, 1, 0, 1, 0, 0, 0, 3'd0, 2'd2, 0);
    HLT = v(4'b0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 1);
    rst = 1'b0; rst2 = 1'b0; zero = 1'b0; instruction = 8'h00; ins2 = 8'h00;
    #2;
    check("rst_async_outs", 32'(outs), 0);
    check("rst_async_cnt", 32'(instr_cnt), 0);
    repeat (2) tick();
    check("rst_hold_outs", 32'(outs), 0);
    rst = 1'b1;
    check("idle_outs", 32'(outs), 0);
    tick(); check("nop_fet1", 32'(outs), 32'(F1));
    tick(); check("nop_fet2", 32'(outs), 32'(F2));
    tick(); check("nop_dec", 32'(outs), 0);
    check("nop_cnt_pre", 32'(instr_cnt), 0);
    tick(); check("nop_fet1b", 32'(outs), 32'(F1));
    check("nop_cnt", 32'(instr_cnt), 1);
    tick(); instruction = 8'h16;
    tick(); check("add_dec", 32'(outs), 32'(v(4'b0, 0, 0, 0, 0, 1, 0, 0, 3'd1, 2'd1, 0)));
    tick(); check("add_ex1", 32'(outs), 32'(v(4'b0100, 0, 0, 0, 0, 0, 1, 0, 3'd2, 2'd0, 0)));
    check("add_cnt_pre", 32'(instr_cnt), 1);
    tick(); check("add_fet1", 32'(outs), 32'(F1));
    check("add_cnt", 32'(instr_cnt), 2);
    tick(); instruction = 8'h47;
    tick(); check("not_dec", 32'(outs), 32'(v(4'b1000, 0, 0, 0, 0, 0, 1, 0, 3'd1, 2'd0, 0)));
    tick(); check("not_fet1", 32'(outs), 32'(F1));
    check("not_cnt", 32'(instr_cnt), 3);
    tick(); instruction = 8'h53;
    tick(); check("rd_dec", 32'(outs), 32'(F1));
    tick(); check("rd_rd1", 32'(outs), 32'(M1));
    tick(); check("rd_rd2", 32'(outs), 32'(v(4'b1000, 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0)));
    tick(); check("rd_cnt", 32'(instr_cnt), 4);
    tick(); instruction = 8'h6C;
    tick(); check("wr_dec", 32'(outs), 32'(F1));
    tick(); check("wr_wr1", 32'(outs), 32'(M1));
    tick(); check("wr_wr2", 32'(outs), 32'(v(4'b0, 0, 0, 0, 0, 0, 0, 1, 3'd3, 2'd0, 0)));
    tick(); check("wr_cnt", 32'(instr_cnt), 5);
    tick(); instruction = 8'h70;
    tick(); check("br_dec", 32'(outs), 32'(F1));
    tick(); check("br_br1", 32'(outs), 32'(v(4'b0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 2'd2, 0)));
    tick(); check("br_br2", 32'(outs), 32'(v(4'b0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0)));
    tick(); check("br_cnt", 32'(instr_cnt), 6);
    tick(); instruction = 8'h80; zero = 1'b1;
    tick();
`ifdef RISC_CTRL_BRZ_EN
    check("brz_t_dec", 32'(outs), 32'(F1));
    tick(); check("brz_t_br1", 32'(outs), 32'(v(4'b0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 2'd2, 0)));
    tick(); check("brz_t_br2", 32'(outs), 32'(v(4'b0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0)));
    tick(); check("brz_t_cnt", 32'(instr_cnt), 7);
    tick(); zero = 1'b0;
    tick(); check("brz_n_dec", 32'(outs), 32'(v(4'b0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0)));
    tick(); check("brz_n_fet1", 32'(outs), 32'(F1));
    check("brz_n_cnt", 32'(instr_cnt), 8);
`else
    check("brz_ill_dec", 32'(outs), 0);
    tick(); check("brz_ill_halt", 32'(outs), 32'(HLT));
    check("brz_ill_cnt", 32'(instr_cnt), 6);
`endif
    zero = 1'b0;
    rst = 1'b0;
    #1 check("rst_pulse_outs", 32'(outs), 0);
    tick(); rst = 1'b1;
    tick(); check("rst_pulse_fet1", 32'(outs), 32'(F1));
    check("rst_pulse_cnt", 32'(instr_cnt), 0);
    tick(); instruction = 8'h6C;
    tick(); tick(); check("wrr_wr1", 32'(outs), 32'(M1));
    rst = 1'b0;
    #1 check("wrr_outs", 32'(outs), 0);
    check("wrr_cnt", 32'(instr_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); check("wrr_write", 32'(write), 0);
    end
    rst = 1'b1;
    check("wrr_idle", 32'(outs), 0);
    tick(); check("wrr_fet1", 32'(outs), 32'(F1));
    check("wrr_write_after", 32'(write), 0);
    instruction = 8'h00;
    tick(); tick(); tick(); check("ill_pre_cnt", 32'(instr_cnt), 1);
    tick(); instruction = 8'h90;
    tick(); check("ill_dec", 32'(outs), 0);
    tick(); check("ill_halt", 32'(outs), 32'(HLT));
    check("ill_cnt", 32'(instr_cnt), 1);
    tick(); tick(); check("ill_halt_stay", 32'(outs), 32'(HLT));
    check("ill_cnt_stay", 32'(instr_cnt), 1);
    rst2 = 1'b1;
    for (int i = 1; i <= 49; i++) begin
      tick();
      if (i == 46) check("wrap_15", 32'(cnt2), 15);
    end
    check("wrap_0", 32'(cnt2), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
